// File: rtl/femto_io_pkg.sv
// rtl/femto_io_pkg.sv - shared state encoding and widths for femto_io blocks
package femto_io_pkg;

  typedef logic [1:0] deb_state_t;

  localparam deb_state_t ST_LOW    = 2'd0;
  localparam deb_state_t ST_CHK_HI = 2'd1;
  localparam deb_state_t ST_HIGH   = 2'd2;
  localparam deb_state_t ST_CHK_LO = 2'd3;

  localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - button debouncer with edge pulses, long-press detect and press counter
module btn_debouncer
  import femto_io_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000000,
  parameter int LONG_CYCLES   = 50000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in,
  input  logic                   clr,
  output logic                   level,
  output logic                   rise,
  output logic                   fall,
  output logic                   long_press,
  output logic                   long_held,
  output logic [PRESS_CNT_W-1:0] press_count
);

  // Stability counter tops out at STABLE_CYCLES-1, hold counter at LONG_CYCLES.
  localparam int STAB_W = $clog2(STABLE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 1);

  deb_state_t             r_state;
  deb_state_t             w_state_nxt;
  logic [STAB_W-1:0]      r_stab_cnt;
  logic [STAB_W-1:0]      w_stab_nxt;
  logic                   w_accept_hi;
  logic                   w_accept_lo;

  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [HOLD_W-1:0]      w_hold_nxt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_long_press;
  logic                   r_long_held;
  logic [PRESS_CNT_W-1:0] r_press_cnt;

  logic                   w_level_nxt;
  logic                   w_long_press_nxt;
  logic                   w_long_held_nxt;
  logic [PRESS_CNT_W-1:0] w_press_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_LOW;
      r_stab_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab_cnt;
    w_accept_hi = 1'b0;
    w_accept_lo = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (in) begin
          w_state_nxt = ST_CHK_HI;
          w_stab_nxt  = STAB_ONE;
        end
      end
      ST_CHK_HI: begin
        if (!in) begin
          w_state_nxt = ST_LOW;
        end else if (r_stab_cnt == STAB_LAST) begin
          w_state_nxt = ST_HIGH;
          w_accept_hi = 1'b1;
        end else begin
          w_stab_nxt = r_stab_cnt + STAB_ONE;
        end
      end
      ST_HIGH: begin
        if (!in) begin
          w_state_nxt = ST_CHK_LO;
          w_stab_nxt  = STAB_ONE;
        end
      end
      ST_CHK_LO: begin
        if (in) begin
          w_state_nxt = ST_HIGH;
        end else if (r_stab_cnt == STAB_LAST) begin
          w_state_nxt = ST_LOW;
          w_accept_lo = 1'b1;
        end else begin
          w_stab_nxt = r_stab_cnt + STAB_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_stab_nxt  = '0;
      end
    endcase
  end

  // Outputs are computed from the next state and then registered.
  always_comb begin
    w_level_nxt      = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_CHK_LO);
    w_hold_nxt       = r_hold_cnt;
    w_long_press_nxt = 1'b0;
    if (w_accept_hi) begin
      w_hold_nxt = '0;
    end else if (r_level && (r_hold_cnt != HOLD_MAX)) begin
      w_hold_nxt       = r_hold_cnt + HOLD_ONE;
      w_long_press_nxt = (r_hold_cnt == HOLD_PRE);
    end
    w_long_held_nxt = w_level_nxt && (w_hold_nxt == HOLD_MAX);
    if (clr) begin
      w_press_cnt_nxt = w_accept_hi ? PRESS_CNT_W'(1) : '0;
    end else if (w_accept_hi) begin
      w_press_cnt_nxt = r_press_cnt + PRESS_CNT_W'(1);
    end else begin
      w_press_cnt_nxt = r_press_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt   <= '0;
      r_level      <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_long_press <= 1'b0;
      r_long_held  <= 1'b0;
      r_press_cnt  <= '0;
    end else begin
      r_hold_cnt   <= w_hold_nxt;
      r_level      <= w_level_nxt;
      r_rise       <= w_accept_hi;
      r_fall       <= w_accept_lo;
      r_long_press <= w_long_press_nxt;
      r_long_held  <= w_long_held_nxt;
      r_press_cnt  <= w_press_cnt_nxt;
    end
  end

  assign level       = r_level;
  assign rise        = r_rise;
  assign fall        = r_fall;
  assign long_press  = r_long_press;
  assign long_held   = r_long_held;
  assign press_count = r_press_cnt;

endmodule

// File: tb/tb_btn_debouncer.sv
// tb/tb_btn_debouncer.sv - randomized and directed bench for btn_debouncer against a run-length model
module tb_btn_debouncer;

  localparam int S = 4;
  localparam int L = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       in;
  logic       clr;
  logic       level;
  logic       rise;
  logic       fall;
  logic       long_press;
  logic       long_held;
  logic [7:0] press_count;

  int total = 0;
  int bad   = 0;

  btn_debouncer #(.STABLE_CYCLES(S), .LONG_CYCLES(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .clr         (clr),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .long_press  (long_press),
    .long_held   (long_held),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  // Model: a level flips once S consecutive samples disagree with it.
  int m_run   = 0;
  int m_hold  = 0;
  int m_cnt   = 0;
  bit m_level = 0;
  bit m_old   = 0;
  bit m_rise  = 0;
  bit m_fall  = 0;
  bit m_lp    = 0;
  bit m_lh    = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_hold = 0; m_cnt = 0;
      m_level = 0; m_rise = 0; m_fall = 0; m_lp = 0; m_lh = 0;
    end else begin
      m_old  = m_level;
      m_rise = 0;
      m_fall = 0;
      m_lp   = 0;
      if (in != m_level) m_run = m_run + 1;
      else               m_run = 0;
      if (m_run == S) begin
        m_level = ~m_level;
        m_run   = 0;
        if (m_level) m_rise = 1;
        else         m_fall = 1;
      end
      if (m_rise) begin
        m_hold = 0;
      end else if (m_old && m_hold < L) begin
        m_hold = m_hold + 1;
        if (m_hold == L) m_lp = 1;
      end
      m_lh = m_level && (m_hold == L);
      if (clr)         m_cnt = m_rise ? 1 : 0;
      else if (m_rise) m_cnt = (m_cnt + 1) % 256;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("level",       {31'd0, level},      {31'd0, m_level});
    chk("rise",        {31'd0, rise},       {31'd0, m_rise});
    chk("fall",        {31'd0, fall},       {31'd0, m_fall});
    chk("long_press",  {31'd0, long_press}, {31'd0, m_lp});
    chk("long_held",   {31'd0, long_held},  {31'd0, m_lh});
    chk("press_count", {24'd0, press_count}, m_cnt);
  end

  task automatic step(input logic i_v, input logic c_v);
    in  = i_v;
    clr = c_v;
    @(posedge clk);
    #1;
  endtask

  task automatic press_release();
    repeat (S) step(1'b1, 1'b0);
    repeat (S) step(1'b0, 1'b0);
  endtask

  int lp_n;
  int lp_at;
  int fall_n;
  int rise_n;

  initial begin
    rst = 1'b1;
    in  = 1'b0;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_level", {31'd0, level}, 32'd0);
    chk("rst_count", {24'd0, press_count}, 32'd0);

    // Clean accept: level and rise on the 4th edge sampling 1.
    repeat (S - 1) step(1'b1, 1'b0);
    chk("pre_accept_level", {31'd0, level}, 32'd0);
    step(1'b1, 1'b0);
    chk("accept_level", {31'd0, level}, 32'd1);
    chk("accept_rise",  {31'd0, rise},  32'd1);
    chk("model_rise",   {31'd0, m_rise}, 32'd1);

    // Long hold: one long_press pulse 16 cycles after rise.
    lp_n = 0; lp_at = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, 1'b0);
      if (k == 1) begin
        chk("rise_one_cycle", {31'd0, rise}, 32'd0);
        chk("count_after_rise", {24'd0, press_count}, 32'd1);
      end
      if (long_press) begin lp_n++; lp_at = k; end
    end
    chk("lp_pulses", lp_n, 32'd1);
    chk("lp_time",   lp_at, 32'd16);
    chk("long_held_30", {31'd0, long_held}, 32'd1);
    chk("model_lh_30",  {31'd0, m_lh}, 32'd1);
    repeat (S - 1) step(1'b0, 1'b0);
    chk("held_before_fall", {31'd0, long_held}, 32'd1);
    step(1'b0, 1'b0);
    chk("fall_pulse", {31'd0, fall}, 32'd1);
    chk("fall_level", {31'd0, level}, 32'd0);
    chk("fall_held",  {31'd0, long_held}, 32'd0);

    // Bounce 1,1,1,0 from LOW is rejected.
    rise_n = 0;
    step(1'b1, 1'b0); rise_n += rise;
    step(1'b1, 1'b0); rise_n += rise;
    step(1'b1, 1'b0); rise_n += rise;
    step(1'b0, 1'b0); rise_n += rise;
    repeat (3) begin step(1'b0, 1'b0); rise_n += rise; end
    chk("bounce_rise", rise_n, 32'd0);
    chk("bounce_level", {31'd0, level}, 32'd0);

    // Bounce 0,0,1 inside a press: no fall, long_press still at 16.
    repeat (S) step(1'b1, 1'b0);
    chk("p2_rise", {31'd0, rise}, 32'd1);
    lp_n = 0; lp_at = 0; fall_n = 0;
    for (int k = 1; k <= 20; k++) begin
      step((k == 6 || k == 7) ? 1'b0 : 1'b1, 1'b0);
      fall_n += fall;
      if (long_press) begin lp_n++; lp_at = k; end
    end
    chk("bounce_fall", fall_n, 32'd0);
    chk("bounce_lp_n", lp_n, 32'd1);
    chk("bounce_lp_at", lp_at, 32'd16);
    repeat (S) step(1'b0, 1'b0);

    // Counter wrap and clear.
    step(1'b0, 1'b1);
    chk("clr_alone", {24'd0, press_count}, 32'd0);
    for (int p = 0; p < 255; p++) press_release();
    chk("count_255", {24'd0, press_count}, 32'd255);
    press_release();
    chk("count_wrap", {24'd0, press_count}, 32'd0);
    repeat (S - 1) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("clr_with_rise", {24'd0, press_count}, 32'd1);
    chk("model_clr_rise", m_cnt, 32'd1);
    repeat (S) step(1'b0, 1'b0);

    // Async reset mid-CHK_HI with in held high.
    repeat (2) step(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", {24'd0, press_count}, 32'd0);
    chk("async_rst_outs", {27'd0, level, rise, fall, long_press, long_held}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rise_n = 0;
    for (int k = 1; k <= S; k++) begin
      step(1'b1, 1'b0);
      if (k < S) rise_n += rise;
    end
    chk("post_rst_early_rise", rise_n, 32'd0);
    chk("post_rst_rise", {31'd0, rise}, 32'd1);

    // Randomized runs, clears and occasional resets.
    for (int r = 0; r < 600; r++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(18, 30)) : int'($urandom_range(1, 7));
      for (int k = 0; k < len; k++) begin
        step(v, ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
        if ($urandom_range(0, 499) == 0) begin
          rst = 1'b1;
          @(posedge clk);
          #1 rst = 1'b0;
        end
      end
    end

    @(posedge clk);
    #6;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debouncer.md
BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1000000, consecutive equal samples needed to accept a level change (legal range >= 2).
REQ-002 SHALL have parameter LONG_CYCLES, default 50000000, debounced-high cycles that qualify a long press (legal when > STABLE_CYCLES).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in  input  1  deglitched, already-synchronised button level; no further synchroniser in this block.
REQ-006 SHALL have port clr  input  1  synchronous clear of press_count.
REQ-007 SHALL have port level  output  1  debounced button level.
REQ-008 SHALL have port rise  output  1  one-cycle pulse on an accepted 0->1 change.
REQ-009 SHALL have port fall  output  1  one-cycle pulse on an accepted 1->0 change.
REQ-010 SHALL have port long_press  output  1  one-cycle pulse when the current press reaches LONG_CYCLES.
REQ-011 SHALL have port long_held  output  1  high while the current press has lasted >= LONG_CYCLES.
REQ-012 SHALL have port press_count  output  8  count of accepted rises, modulo 256.

Function
REQ-013 SHALL implement FSM states LOW, CHK_HI, HIGH, CHK_LO; level = 1 in HIGH and CHK_LO, 0 otherwise.
REQ-014 LOW: in=1 -> CHK_HI, stability counter := 1; in=0 -> stay.
REQ-015 CHK_HI: in=0 -> LOW (bounce rejected, no pulse); in=1 with counter = STABLE_CYCLES-1 -> HIGH; else counter +1.
REQ-016 HIGH: in=0 -> CHK_LO, counter := 1; in=1 -> stay.
REQ-017 CHK_LO: in=1 -> HIGH (bounce rejected, no pulse); in=0 with counter = STABLE_CYCLES-1 -> LOW; else counter +1.
REQ-018 Latency: level changes on the edge where in has been sampled at its new value on STABLE_CYCLES consecutive edges; rise/fall assert for exactly that one following cycle.
REQ-019 All outputs SHALL be registered; no combinational path from in or clr to any output.
REQ-020 Hold counter SHALL clear to 0 on CHK_HI->HIGH, increment each cycle while level=1, saturate at LONG_CYCLES, and remain at its value while level=0.
REQ-021 long_press SHALL pulse once per press, on the edge the hold counter goes LONG_CYCLES-1 -> LONG_CYCLES; long_held SHALL be hold counter = LONG_CYCLES and level = 1.
REQ-022 A CHK_LO bounce returning to HIGH SHALL not clear the hold counter (same press continues).
REQ-023 press_count SHALL increment on each rise; 255 wraps to 0.
REQ-024 clr and rise in the same cycle SHALL yield press_count = 1; clr alone yields 0.
REQ-025 Counter widths SHALL be $clog2 of their maximum value + 1; no truncation at default parameters.

Reset
REQ-026 rst=1 SHALL asynchronously force state LOW, both counters 0, press_count 0, and all outputs 0.
REQ-027 If in=1 at rst deassertion, level SHALL assert only after STABLE_CYCLES qualifying samples (no reset-time rise bypass).
REQ-028 Reset mid-press SHALL suppress any pending rise, fall, or long_press pulse.

Structure
REQ-029 State encoding localparams and the 8-bit press_count width SHALL live in the shared package/header femto_io_pkg; STABLE_CYCLES/LONG_CYCLES stay module parameters.
REQ-030 Single module, no sub-modules; the FPGA wrapper instantiates it between the button deglitcher and the gpio input of top.

Verification (bench: STABLE_CYCLES=4, LONG_CYCLES=16)
REQ-031 in 0->1 held -> level=1 and rise=1 for one cycle on the 4th edge sampling in=1; press_count=1.
REQ-032 in pattern 1,1,1,0 from LOW -> no rise, level stays 0, state back to LOW.
REQ-033 in held 1 for 30 cycles after accept -> long_press exactly one pulse 16 cycles after rise; long_held=1 until fall.
REQ-034 During HIGH, in 0,0,1 bounce -> no fall, long_press timing unchanged.
REQ-035 256 clean presses -> press_count=0; clr asserted with 257th rise -> press_count=1.
REQ-036 rst pulsed mid-CHK_HI with in=1 held -> all outputs 0 immediately; rise appears 4 edges after rst deasserts.
